// File: rtl/dm_dump_ctrl.sv
// dm_dump_ctrl: when the processor halts, stream every data-memory word
// (addresses 0..MEM_SIZE-1) out through a byte-wide UART transmitter, with
// the high byte of each word sent first.
//
// Handshake with the transmitter: o_tx_start is a one-cycle request that
// carries o_tx_data. The byte stays valid until the transmitter returns a
// one-cycle i_tx_done. Only the two WAIT states look at i_tx_done, so a
// stray pulse at any other time has no effect.
//
// DATA_LENGTH must equal 2*BYTE_WIDTH. A word is split into exactly two
// bytes.
module dm_dump_ctrl #(
    parameter int MEM_SIZE    = 9,
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_halt,
    input  logic [DATA_LENGTH-1:0] i_Data,
    input  logic                   i_tx_done,
    output logic [ADDR_LENGTH-1:0] o_Addr,
    output logic                   o_Rd,
    output logic                   o_tx_start,
    output logic [BYTE_WIDTH-1:0]  o_tx_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        SEND_HI = 3'd2,
        WAIT_HI = 3'd3,
        SEND_LO = 3'd4,
        WAIT_LO = 3'd5,
        NEXT    = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(MEM_SIZE - 1);

    state_t                 state;
    logic                   halt_q;
    logic [ADDR_LENGTH-1:0] count;
    logic [DATA_LENGTH-1:0] word;

    // The memory address is always the word counter.
    assign o_Addr      = count;
    assign o_dbg_state = state;

    // Register halt every cycle so that IDLE can detect a rising edge.
    // Because reset clears halt_q, a halt that is already high when reset
    // is released counts as a new edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= i_halt;
        end
    end

    // Dump sequencer. All outputs are registered. Each one is set on the
    // transition into the state that owns it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            count      <= '0;
            word       <= '0;
            o_Rd       <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (i_halt && !halt_q) begin
                        state  <= READ;
                        o_Rd   <= 1'b1;
                        o_busy <= 1'b1;
                    end
                end
                READ: begin
                    // Memory read is combinational, so i_Data is already
                    // valid for this address. The high byte is forwarded
                    // directly so that it is sent in the next cycle.
                    word       <= i_Data;
                    o_Rd       <= 1'b0;
                    o_tx_start <= 1'b1;
                    o_tx_data  <= i_Data[DATA_LENGTH-1:BYTE_WIDTH];
                    state      <= SEND_HI;
                end
                SEND_HI: begin
                    o_tx_start <= 1'b0;
                    state      <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (i_tx_done) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= word[BYTE_WIDTH-1:0];
                        state      <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    o_tx_start <= 1'b0;
                    state      <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (i_tx_done) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (count == LAST_ADDR) begin
                        count  <= '0;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                        o_Rd  <= 1'b1;
                        state <= READ;
                    end
                end
                DONE: begin
                    // Stay here while the processor remains halted. A
                    // release that happened during the dump makes this
                    // state last exactly one cycle.
                    if (!i_halt) begin
                        o_done <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    count      <= '0;
                    o_Rd       <= 1'b0;
                    o_tx_start <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_dump_ctrl.sv
// Bench for dm_dump_ctrl. A dump is modelled as the list of bytes
// {mem[k][15:8], mem[k][7:0]} for k = 0..MEM_SIZE-1, together with the list
// of addresses read. Both lists are queued when a dump is triggered. A
// monitor pops the queues on every read strobe and every transmit request.
// A UART responder answers each request after a programmable delay.
module tb_dm_dump_ctrl;

    localparam int MEM_SIZE = 9;
    localparam int AW       = 11;
    localparam int DW       = 16;
    localparam int BW       = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt = 1'b0;
    logic [DW-1:0] i_data;
    logic          i_tx_done = 1'b0;
    logic [AW-1:0] o_addr;
    logic          o_rd;
    logic          o_tx_start;
    logic [BW-1:0] o_tx_data;
    logic          o_busy;
    logic          o_done;
    logic [2:0]    o_dbg_state;

    dm_dump_ctrl #(
        .MEM_SIZE   (MEM_SIZE),
        .ADDR_LENGTH(AW),
        .DATA_LENGTH(DW),
        .BYTE_WIDTH (BW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_halt     (halt),
        .i_Data     (i_data),
        .i_tx_done  (i_tx_done),
        .o_Addr     (o_addr),
        .o_Rd       (o_rd),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [16];
    assign i_data = (o_addr < AW'(MEM_SIZE)) ? mem[o_addr[3:0]] : 16'hdead;

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            checks = 0;
    int            errors = 0;
    int            n_starts = 0;
    int            tx_delay = 3;
    bit            spurious = 1'b0;
    int            cd = 0;
    bit            awaiting = 1'b0;
    bit            prev_start = 1'b0;
    bit            have_last = 1'b0;
    logic [BW-1:0] last_byte = '0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill_pattern();
        for (int k = 0; k < 16; k++) mem[k] = 16'h1230 + 16'(k);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++) mem[k] = 16'($urandom_range(0, 65535));
    endtask

    task automatic push_dump();
        for (int k = 0; k < MEM_SIZE; k++) begin
            exp_addr_q.push_back(AW'(k));
            exp_q.push_back(mem[k][15:8]);
            exp_q.push_back(mem[k][7:0]);
        end
    endtask

    // Enter IDLE with halt low for one cycle, then raise halt and queue the
    // dump.
    task automatic start_dump();
        halt = 1'b0;
        @(negedge clk);
        push_dump();
        halt = 1'b1;
    endtask

    task automatic wait_done(string name, int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, o_done, 1);
        check({name, "_queue_empty"}, exp_q.size() + exp_addr_q.size(), 0);
        check({name, "_addr_zero"}, o_addr, 0);
    endtask

    // ---------------- monitor + UART responder ----------------
    always @(negedge clk) begin
        if (rst) begin
            cd         = 0;
            awaiting   = 1'b0;
            i_tx_done  = 1'b0;
            prev_start = 1'b0;
            have_last  = 1'b0;
        end else begin
            if (o_tx_start) begin
                n_starts++;
                check("start_not_consecutive", prev_start, 0);
                check("start_after_tx_done", awaiting, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start got %0h expected none", o_tx_data);
                end else begin
                    check("tx_byte", o_tx_data, exp_q.pop_front());
                end
                last_byte = o_tx_data;
                have_last = 1'b1;
                awaiting  = 1'b1;
            end else if (o_busy && have_last) begin
                check("tx_data_hold", o_tx_data, last_byte);
            end
            if (o_rd) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read got %0h expected none", o_addr);
                end else begin
                    check("read_addr", o_addr, exp_addr_q.pop_front());
                end
            end
            if (o_done) check("done_quiet", {o_busy, o_rd, o_tx_start}, 0);
            prev_start = o_tx_start;

            i_tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    i_tx_done = 1'b1;
                    awaiting  = 1'b0;
                end
            end
            if (o_tx_start) begin
                cd = tx_delay;
                if (spurious) i_tx_done = 1'b1;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int base;
        fill_pattern();
        #1;
        check("reset_outputs", {o_addr, o_rd, o_tx_start, o_tx_data, o_busy, o_done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", {o_addr, o_rd, o_tx_start, o_busy, o_done}, 0);

        // Basic dump with the fixed pattern, including first-word latency.
        tx_delay = 3;
        push_dump();
        halt = 1'b1;
        @(negedge clk);
        check("latency_rd", {o_rd, o_addr}, {1'b1, 11'd0});
        @(negedge clk);
        check("latency_tx", {o_tx_start, o_tx_data}, {1'b1, 8'h12});
        wait_done("basic_done", 500);
        halt = 1'b0;
        repeat (2) @(negedge clk);
        check("basic_back_idle", {o_done, o_busy}, 0);

        // Slow transmitter, with a spurious done during each SEND cycle.
        fill_random();
        tx_delay = 50;
        spurious = 1'b1;
        start_dump();
        wait_done("slow_done", 3000);
        spurious = 1'b0;
        halt = 1'b0;
        repeat (2) @(negedge clk);

        // Halt held high: DONE persists and there is no second dump.
        // A one-cycle low pulse then triggers exactly one new dump.
        fill_random();
        tx_delay = $urandom_range(1, 6);
        start_dump();
        wait_done("level_done", 1000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("level_done_held", o_done, 1);
        end
        fill_random();
        tx_delay = $urandom_range(1, 6);
        start_dump();
        wait_done("repulse_done", 1000);
        repeat (5) @(negedge clk);
        halt = 1'b0;
        repeat (2) @(negedge clk);

        // Early release: halt dropped during word 4.
        fill_random();
        tx_delay = $urandom_range(1, 6);
        start_dump();
        n = 0;
        while (!(o_rd && o_addr == 11'd4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("early_saw_word4", o_rd && o_addr == 11'd4, 1);
        halt = 1'b0;
        wait_done("early_done", 1000);
        @(negedge clk);
        check("early_done_one_cycle", {o_done, o_busy}, 0);
        repeat (3) @(negedge clk);

        // Reset during WAIT_LO of word 2 abandons the dump.
        fill_random();
        tx_delay = 4;
        base = n_starts;
        start_dump();
        n = 0;
        while (n_starts < base + 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_outputs", {o_addr, o_rd, o_tx_start, o_tx_data, o_busy, o_done}, 0);
        exp_q.delete();
        exp_addr_q.delete();
        halt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midreset_stays_idle", {o_busy, o_done}, 0);
        fill_random();
        start_dump();
        wait_done("after_reset_done", 1000);
        halt = 1'b0;
        repeat (2) @(negedge clk);

        // Halt already high when reset is released starts a dump.
        rst = 1'b1;
        halt = 1'b1;
        fill_random();
        repeat (2) @(negedge clk);
        push_dump();
        rst = 1'b0;
        wait_done("release_high_done", 1000);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", {o_busy, o_done, o_addr}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
